// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the double-buffered 64x32 RGB444 frame buffer.
package frame_buf_pkg;

   localparam int unsigned PIX_WIDTH   = 12;
   localparam int unsigned ADDR_WIDTH  = 10;
   localparam int unsigned COL_BITS    = 6;
   localparam int unsigned ROW_BITS    = ADDR_WIDTH - COL_BITS;
   localparam int unsigned WADDR_WIDTH = ADDR_WIDTH + 1;
   localparam int unsigned RAM_DEPTH   = 1 << ADDR_WIDTH;

   typedef logic [PIX_WIDTH-1:0] pixel_t;

   localparam pixel_t DEF_CLEAR_COLOR = PIX_WIDTH'(0);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CLEAR     = 2'd1,
      SWAP_WAIT = 2'd2
   } state_e;

   // One write into the back bank, shared by renderer writes and the clear sweep.
   typedef struct packed {
      logic                  we_top;
      logic                  we_btm;
      logic [ADDR_WIDTH-1:0] addr;
      pixel_t                data;
   } wr_port_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fb_ram
   import frame_buf_pkg::*;
(
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  pixel_t                i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output pixel_t                o_rdata
);

   pixel_t r_mem [RAM_DEPTH];
   pixel_t r_rdata;

   // Write and registered read; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buf.sv
// Double-buffered pixel memory feeding the display controller; bank swaps are
// deferred to the row 15 -> row 0 transition on the read address.
module frame_buf
   import frame_buf_pkg::*;
#(
   parameter pixel_t CLEAR_COLOR = DEF_CLEAR_COLOR
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  r_addr,
   output logic [PIX_WIDTH-1:0]   pix_top,
   output logic [PIX_WIDTH-1:0]   pix_btm,
   input  logic                   wr_en,
   input  logic [WADDR_WIDTH-1:0] wr_addr,
   input  logic [PIX_WIDTH-1:0]   wr_data,
   output logic                   wr_ready,
   input  logic                   swap_req,
   input  logic                   clr_req,
   output logic                   req_ready,
   output logic                   swap_ack,
   output logic                   clr_done,
   output logic                   front_bank
);

   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

   state_e                r_state;
   state_e                w_state_nxt;
   logic [ROW_BITS-1:0]   r_prev_row;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic                  r_front;
   logic                  r_rd_bank;
   logic                  r_rd_valid;
   logic                  r_swap_ack;
   logic                  r_clr_done;
   logic                  r_ready;

   logic                  w_boundary;
   logic                  w_idle;
   logic                  w_clearing;
   logic                  w_flip;
   logic                  w_clr_last;
   logic                  w_back;
   wr_port_t              w_wr;
   logic [1:0][1:0]       w_ram_we;
   pixel_t                w_ram_q [2][2];

   // Frame boundary: previous read row was the last row, current read is row 0.
   assign w_boundary = (r_prev_row == '1) && (r_addr[ADDR_WIDTH-1:COL_BITS] == '0);
   assign w_back     = ~r_front;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a simultaneous clear request wins over swap.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (clr_req) begin
               w_state_nxt = CLEAR;
            end else if (swap_req) begin
               w_state_nxt = SWAP_WAIT;
            end
         end
         CLEAR: begin
            if (r_clr_cnt == CNT_LAST) begin
               w_state_nxt = IDLE;
            end
         end
         SWAP_WAIT: begin
            if (w_boundary) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State-decoded controls for the datapath.
   always_comb begin
      w_idle     = 1'b0;
      w_clearing = 1'b0;
      w_flip     = 1'b0;
      w_clr_last = 1'b0;
      unique case (r_state)
         IDLE:      w_idle = 1'b1;
         CLEAR: begin
            w_clearing = 1'b1;
            w_clr_last = (r_clr_cnt == CNT_LAST);
         end
         SWAP_WAIT: w_flip = w_boundary;
         default:   w_idle = 1'b0;
      endcase
   end

   // Back-bank write port: clear sweep writes both halves, renderer writes one.
   always_comb begin
      w_wr = '0;
      if (w_clearing) begin
         w_wr.we_top = 1'b1;
         w_wr.we_btm = 1'b1;
         w_wr.addr   = r_clr_cnt;
         w_wr.data   = CLEAR_COLOR;
      end else if (w_idle) begin
         w_wr.we_top = wr_en & ~wr_addr[WADDR_WIDTH-1];
         w_wr.we_btm = wr_en &  wr_addr[WADDR_WIDTH-1];
         w_wr.addr   = wr_addr[ADDR_WIDTH-1:0];
         w_wr.data   = wr_data;
      end
   end

   // Route the write enables to the back bank only.
   always_comb begin
      w_ram_we            = '0;
      w_ram_we[w_back][0] = w_wr.we_top;
      w_ram_we[w_back][1] = w_wr.we_btm;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar h = 0; h < 2; h++) begin : g_half
         fb_ram u_ram (
            .clk     (clk),
            .i_we    (w_ram_we[b][h]),
            .i_waddr (w_wr.addr),
            .i_wdata (w_wr.data),
            .i_raddr (r_addr),
            .o_rdata (w_ram_q[b][h])
         );
      end
   end

   // Frame tracking, bank flip, clear counter and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev_row <= '0;
         r_clr_cnt  <= '0;
         r_front    <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_swap_ack <= 1'b0;
         r_clr_done <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_prev_row <= r_addr[ADDR_WIDTH-1:COL_BITS];
         r_rd_bank  <= r_front ^ w_flip;
         r_rd_valid <= 1'b1;
         r_swap_ack <= w_flip;
         r_clr_done <= w_clr_last;
         r_ready    <= (w_state_nxt == IDLE);
         if (w_flip) begin
            r_front <= ~r_front;
         end
         if (w_idle && clr_req) begin
            r_clr_cnt <= '0;
         end else if (w_clearing) begin
            r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
         end
      end
   end

   assign pix_top    = r_rd_valid ? w_ram_q[r_rd_bank][0] : '0;
   assign pix_btm    = r_rd_valid ? w_ram_q[r_rd_bank][1] : '0;
   assign wr_ready   = r_ready;
   assign req_ready  = r_ready;
   assign swap_ack   = r_swap_ack;
   assign clr_done   = r_clr_done;
   assign front_bank = r_front;

endmodule

// File: tb/tb_frame_buf.sv
// Self-checking bench for frame_buf: directed scenarios plus randomized traffic
// against a transaction-level model of the two banks.
module tb_frame_buf;

   logic        clk;
   logic        d_rst_n;
   logic [9:0]  d_raddr;
   logic        d_wr_en;
   logic [10:0] d_wr_addr;
   logic [11:0] d_wr_data;
   logic        d_swap;
   logic        d_clr;
   logic [11:0] pix_top;
   logic [11:0] pix_btm;
   logic        wr_ready;
   logic        req_ready;
   logic        swap_ack;
   logic        clr_done;
   logic        front_bank;

   int n_vec = 0;
   int n_err = 0;

   // Model: bank contents with known flags, displayed bank, pending operations.
   logic [11:0] m_mem [2][2048];
   bit          m_kn  [2][2048];
   bit          m_front;
   bit          m_swap_pend;
   int          m_clr_left;
   logic [3:0]  m_prev_row;

   logic [11:0] e_pix_top, e_pix_btm;
   bit          e_kn_top, e_kn_btm;
   bit          e_swap_ack, e_clr_done, e_ready, e_front;

   frame_buf dut (
      .clk        (clk),
      .rst        (d_rst_n),
      .r_addr     (d_raddr),
      .pix_top    (pix_top),
      .pix_btm    (pix_btm),
      .wr_en      (d_wr_en),
      .wr_addr    (d_wr_addr),
      .wr_data    (d_wr_data),
      .wr_ready   (wr_ready),
      .swap_req   (d_swap),
      .clr_req    (d_clr),
      .req_ready  (req_ready),
      .swap_ack   (swap_ack),
      .clr_done   (clr_done),
      .front_bank (front_bank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input bit wipe_back);
      if (wipe_back) begin
         for (int i = 0; i < 2048; i++) m_kn[m_front ? 0 : 1][i] = 1'b0;
      end
      m_front = 1'b0; m_swap_pend = 1'b0; m_clr_left = 0; m_prev_row = '0;
      e_pix_top = '0; e_pix_btm = '0; e_kn_top = 1'b1; e_kn_btm = 1'b1;
      e_swap_ack = 1'b0; e_clr_done = 1'b0; e_ready = 1'b1; e_front = 1'b0;
   endtask

   // Advance the model by one clock using the currently driven inputs.
   task automatic model_step();
      bit idle, flip;
      int rb, nb;
      idle = (m_clr_left == 0) && !m_swap_pend;
      flip = m_swap_pend && (m_prev_row == 4'd15) && (d_raddr[9:6] == 4'd0);
      rb   = (m_front ^ flip) ? 1 : 0;
      nb   = m_front ? 0 : 1;
      e_pix_top  = m_mem[rb][{1'b0, d_raddr}];
      e_pix_btm  = m_mem[rb][{1'b1, d_raddr}];
      e_kn_top   = m_kn[rb][{1'b0, d_raddr}];
      e_kn_btm   = m_kn[rb][{1'b1, d_raddr}];
      e_swap_ack = flip;
      e_clr_done = (m_clr_left == 1);
      if (idle) begin
         if (d_wr_en) begin
            m_mem[nb][d_wr_addr] = d_wr_data;
            m_kn[nb][d_wr_addr]  = 1'b1;
         end
         if (d_clr) begin
            for (int i = 0; i < 2048; i++) begin
               m_mem[nb][i] = 12'h000;
               m_kn[nb][i]  = 1'b1;
            end
            m_clr_left = 1024;
         end else if (d_swap) begin
            m_swap_pend = 1'b1;
         end
      end else if (m_clr_left != 0) begin
         m_clr_left--;
      end else if (flip) begin
         m_front     = !m_front;
         m_swap_pend = 1'b0;
      end
      m_prev_row = d_raddr[9:6];
      e_ready    = (m_clr_left == 0) && !m_swap_pend;
      e_front    = m_front;
   endtask

   // One clock: model step, edge, then compare all outputs 1 time unit later.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      if (e_kn_top) chk("pix_top", 32'(pix_top), 32'(e_pix_top));
      if (e_kn_btm) chk("pix_btm", 32'(pix_btm), 32'(e_pix_btm));
      chk("swap_ack",   32'(swap_ack),   32'(e_swap_ack));
      chk("clr_done",   32'(clr_done),   32'(e_clr_done));
      chk("wr_ready",   32'(wr_ready),   32'(e_ready));
      chk("req_ready",  32'(req_ready),  32'(e_ready));
      chk("front_bank", 32'(front_bank), 32'(e_front));
   endtask

   task automatic go_boundary();
      d_raddr = 10'(15 << 6); cycle();
      d_raddr = 10'd0;        cycle();
   endtask

   task automatic do_swap();
      d_swap = 1'b1; cycle(); d_swap = 1'b0;
      go_boundary();
   endtask

   task automatic wait_clr_done(output int n);
      n = 0;
      while (clr_done !== 1'b1 && n < 2000) begin
         cycle();
         n++;
      end
   endtask

   initial begin
      int n, pulses;
      d_rst_n = 1'b1; d_raddr = '0; d_wr_en = 1'b0; d_wr_addr = '0;
      d_wr_data = '0; d_swap = 1'b0; d_clr = 1'b0;
      model_reset(1'b0);

      // Reset values
      #2 d_rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pix_top",  32'(pix_top),    32'h0);
      chk("rst_pix_btm",  32'(pix_btm),    32'h0);
      chk("rst_swap_ack", 32'(swap_ack),   32'h0);
      chk("rst_clr_done", 32'(clr_done),   32'h0);
      chk("rst_front",    32'(front_bank), 32'h0);
      chk("rst_ready",    32'(wr_ready),   32'h1);
      d_rst_n = 1'b1;

      // Basic write + swap at frame boundary
      d_wr_en = 1'b1; d_wr_addr = 11'd0;    d_wr_data = 12'hF00; cycle();
      d_wr_addr = 11'd1024; d_wr_data = 12'h0F0; cycle();
      d_wr_en = 1'b0;
      do_swap();
      chk("t1_ack",     32'(swap_ack),   32'h1);
      chk("t1_front",   32'(front_bank), 32'h1);
      chk("t1_pix_top", 32'(pix_top),    32'hF00);
      chk("t1_pix_btm", 32'(pix_btm),    32'h0F0);
      cycle();
      chk("t1_ack_once", 32'(swap_ack), 32'h0);

      // Swap held off while reads stay in row 3
      d_raddr = 10'(3 << 6);
      d_swap = 1'b1; cycle(); d_swap = 1'b0;
      repeat (5000) cycle();
      chk("t2_wr_ready", 32'(wr_ready), 32'h0);
      chk("t2_no_ack",   32'(swap_ack), 32'h0);
      go_boundary();
      chk("t2_ack",   32'(swap_ack),   32'h1);
      chk("t2_front", 32'(front_bank), 32'h0);

      // Prefill back bank, clear it, swap it in and sweep
      d_raddr = '0;
      for (int i = 0; i < 2048; i++) begin
         d_wr_en = 1'b1; d_wr_addr = 11'(i); d_wr_data = 12'hABC; cycle();
      end
      d_wr_en = 1'b0;
      d_clr = 1'b1; cycle(); d_clr = 1'b0;
      wait_clr_done(n);
      chk("t3_clr_latency", 32'(n), 32'd1024);
      d_swap = 1'b1; cycle(); d_swap = 1'b0;
      for (int i = 0; i < 1024; i++) begin d_raddr = 10'(i); cycle(); end
      for (int i = 0; i < 1024; i++) begin
         d_raddr = 10'(i); cycle();
         chk("t3_clr_top", 32'(pix_top), 32'h0);
         chk("t3_clr_btm", 32'(pix_btm), 32'h0);
      end
      chk("t3_front", 32'(front_bank), 32'h1);

      // Clear and swap together: clear wins, swap is dropped
      d_clr = 1'b1; d_swap = 1'b1; cycle(); d_clr = 1'b0; d_swap = 1'b0;
      chk("t4_in_clear", 32'(wr_ready), 32'h0);
      wait_clr_done(n);
      chk("t4_clr_latency", 32'(n), 32'd1024);
      pulses = 0;
      for (int k = 0; k < 2048; k++) begin
         d_raddr = 10'(k); cycle();
         if (swap_ack === 1'b1) pulses++;
      end
      chk("t4_no_ack", 32'(pulses), 32'd0);
      chk("t4_front",  32'(front_bank), 32'h1);

      // Write during SWAP_WAIT is ignored
      d_wr_en = 1'b1; d_wr_addr = 11'd5; d_wr_data = 12'h555; cycle();
      d_wr_en = 1'b0;
      d_swap = 1'b1; cycle(); d_swap = 1'b0;
      d_wr_en = 1'b1; d_wr_addr = 11'd5; d_wr_data = 12'h123; cycle();
      d_wr_en = 1'b0;
      go_boundary();
      d_raddr = 10'd5; cycle();
      chk("t5_addr5_a", 32'(pix_top), 32'h555);
      do_swap();
      do_swap();
      d_raddr = 10'd5; cycle();
      chk("t5_addr5_b", 32'(pix_top), 32'h555);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         d_wr_en   = ($urandom_range(0, 1) == 1);
         d_wr_addr = 11'($urandom_range(0, 2047));
         d_wr_data = 12'($urandom);
         d_clr     = ($urandom_range(0, 399) == 0);
         d_swap    = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 99) == 0) d_raddr = 10'($urandom);
         else                            d_raddr = d_raddr + 10'd1;
         cycle();
      end
      d_wr_en = 1'b0; d_clr = 1'b0; d_swap = 1'b0;

      // Reset in the middle of a clear
      n = 0;
      while (wr_ready !== 1'b1 && n < 3000) begin
         d_raddr = d_raddr + 10'd1; cycle(); n++;
      end
      chk("t6_drain_idle", 32'(wr_ready), 32'h1);
      if (!m_front) do_swap();
      d_clr = 1'b1; cycle(); d_clr = 1'b0;
      repeat (500) cycle();
      #2 d_rst_n = 1'b0;
      #1;
      chk("t6_rst_front",    32'(front_bank), 32'h0);
      chk("t6_rst_ready",    32'(wr_ready),   32'h1);
      chk("t6_rst_reqready", 32'(req_ready),  32'h1);
      chk("t6_rst_clrdone",  32'(clr_done),   32'h0);
      chk("t6_rst_ack",      32'(swap_ack),   32'h0);
      chk("t6_rst_pix_top",  32'(pix_top),    32'h0);
      chk("t6_rst_pix_btm",  32'(pix_btm),    32'h0);
      model_reset(1'b1);
      @(posedge clk);
      #1 d_rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 1100; k++) begin
         d_raddr = 10'(k); cycle();
         if (clr_done === 1'b1) pulses++;
      end
      chk("t6_no_clr_done", 32'(pulses), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
